// File: rtl/fixed_linear_weight_source.sv
// Streams a pre-partitioned weight matrix out of a synchronous RAM as a valid/ready
// beat sequence, replayed REPEAT times per start pulse.
module fixed_linear_weight_source #(
  parameter int WEIGHT_PRECISION_0           = 16,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0  = 8,
  parameter int DATA_IN_0_PARALLELISM_DIM_0  = 4,
  parameter int DATA_OUT_0_TENSOR_SIZE_DIM_0 = 8,
  parameter int WEIGHT_PARALLELISM_DIM_0     = 4,
  parameter int REPEAT                       = 1,
  localparam int IN_0_DEPTH = DATA_IN_0_TENSOR_SIZE_DIM_0 / DATA_IN_0_PARALLELISM_DIM_0,
  localparam int OUT_DEPTH  = DATA_OUT_0_TENSOR_SIZE_DIM_0 / WEIGHT_PARALLELISM_DIM_0,
  localparam int BEATS      = IN_0_DEPTH * OUT_DEPTH,
  localparam int BEAT_ELEMS = WEIGHT_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_0,
  localparam int AW         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WEIGHT_PRECISION_0-1:0] wr_data [BEAT_ELEMS],
  input  logic [AW-1:0]                 wr_addr,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [WEIGHT_PRECISION_0-1:0] weight [BEAT_ELEMS],
  output logic                          weight_valid,
  input  logic                          weight_ready
);

  localparam int BW = WEIGHT_PRECISION_0 * BEAT_ELEMS;
  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [AW:0]   BEATS_EXT = (AW + 1)'(BEATS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(BEATS - 1);
  localparam logic [RW-1:0] LAST_REP  = RW'(REPEAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [RW-1:0]   rep_q, rep_d;
  logic            rd_valid_q, rd_valid_d;
  logic [BW-1:0]   rd_data_q;
  logic [BW-1:0]   fifo_q [2];
  logic [BW-1:0]   fifo_d [2];
  logic            fifo_rd_ptr_q, fifo_rd_ptr_d;
  logic            fifo_wr_ptr_q, fifo_wr_ptr_d;
  logic [1:0]      fifo_cnt_q, fifo_cnt_d;
  logic            done_q, done_d;

  logic [BW-1:0]   mem [BEATS];
  logic [BW-1:0]   wr_bus;
  logic [BW-1:0]   out_bus;
  logic [1:0]      occupancy;
  logic            wr_en, issue, out_valid, pop, push, fifo_pop, final_hs;

  for (genvar gi = 0; gi < BEAT_ELEMS; gi++) begin : g_elems
    assign wr_bus[gi*WEIGHT_PRECISION_0 +: WEIGHT_PRECISION_0] = wr_data[gi];
    assign weight[gi] = out_bus[gi*WEIGHT_PRECISION_0 +: WEIGHT_PRECISION_0];
  end

  assign busy         = (state_q != S_IDLE);
  assign wr_ready     = !busy;
  assign done         = done_q;
  assign wr_en        = wr_valid && wr_ready && ({1'b0, wr_addr} < BEATS_EXT);
  // In-flight RAM read counts against the 2-entry budget, so ready never reaches the address.
  assign occupancy    = fifo_cnt_q + {1'b0, rd_valid_q};
  assign issue        = (state_q == S_RUN) && (occupancy < 2'd2);
  assign out_valid    = (fifo_cnt_q != 2'd0) || rd_valid_q;
  assign weight_valid = out_valid;
  assign out_bus      = (fifo_cnt_q != 2'd0) ? fifo_q[fifo_rd_ptr_q] : rd_data_q;
  assign pop          = out_valid && weight_ready;
  assign fifo_pop     = pop && (fifo_cnt_q != 2'd0);
  // Fresh RAM data bypasses the FIFO only when it is empty and the beat is taken now.
  assign push         = rd_valid_q && !((fifo_cnt_q == 2'd0) && weight_ready);
  assign final_hs     = (state_q == S_DRAIN) && pop && (occupancy == 2'd1);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_bus;
    if (issue) rd_data_q <= mem[addr_q];
  end

  always_comb begin
    fifo_d        = fifo_q;
    fifo_wr_ptr_d = fifo_wr_ptr_q;
    fifo_rd_ptr_d = fifo_rd_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;
    if (push) begin
      fifo_d[fifo_wr_ptr_q] = rd_data_q;
      fifo_wr_ptr_d         = !fifo_wr_ptr_q;
    end
    if (fifo_pop) fifo_rd_ptr_d = !fifo_rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, fifo_pop};
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rep_d      = rep_q;
    rd_valid_d = issue;
    done_d     = final_hs;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          addr_d  = '0;
          rep_d   = '0;
        end
      end
      S_RUN: begin
        if (issue) begin
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            if (rep_q == LAST_REP) begin
              rep_d   = '0;
              state_d = S_DRAIN;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (final_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      rep_q         <= '0;
      rd_valid_q    <= 1'b0;
      fifo_rd_ptr_q <= 1'b0;
      fifo_wr_ptr_q <= 1'b0;
      fifo_cnt_q    <= 2'd0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rep_q         <= rep_d;
      rd_valid_q    <= rd_valid_d;
      fifo_rd_ptr_q <= fifo_rd_ptr_d;
      fifo_wr_ptr_q <= fifo_wr_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      done_q        <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) fifo_q[i] <= fifo_d[i];
  end

endmodule
